// File: rtl/fifo_sync_arb_ctrl.sv
// Arbitrated write / sequenced read front-end for a shared fifo_sync.
// Occupancy is tracked here because fifo_sync exposes no flags. The count
// moves when a transfer is accepted, one cycle before the FIFO strobe.
module fifo_sync_arb_ctrl #(
  parameter int NUM_REQ = 4,
  parameter int DW      = 8,
  parameter int DEPTH   = 16,
  parameter int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ctrl_en,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*DW-1:0] req_data,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic                  rd_req,
  output logic [DW-1:0]         rd_data,
  output logic                  rd_valid,
  output logic                  fifo_en,
  output logic [DW-1:0]         fifo_data_i,
  output logic                  fifo_read,
  input  logic [DW-1:0]         fifo_data_o,
  input  logic                  fifo_data_rd,
  output logic [CNT_W-1:0]      count,
  output logic                  full,
  output logic                  empty,
  output logic                  err
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(NUM_REQ - 1);
  localparam logic [PTR_W:0]   NREQ_C  = (PTR_W + 1)'(NUM_REQ);

  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] winner;
  logic [PTR_W:0]   scan;
  logic [DW-1:0]    win_data;
  logic             grant_ok;
  logic             wr_acc;
  logic             rd_acc;

  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);

  // Grants are held off while in reset so req_ready shows its reset value
  // asynchronously, not only after the next edge.
  assign grant_ok = rst_n & ctrl_en & ~full;
  assign rd_acc   = rd_req & ctrl_en & ~empty;

  // Round-robin search from rr_ptr; first valid requester wins the grant.
  always_comb begin
    req_ready = '0;
    winner    = '0;
    wr_acc    = 1'b0;
    scan      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan = {1'b0, rr_ptr} + (PTR_W + 1)'(k);
      if (scan >= NREQ_C) begin
        scan = scan - NREQ_C;
      end
      if (grant_ok && !wr_acc && req_valid[scan[PTR_W-1:0]]) begin
        wr_acc                      = 1'b1;
        winner                      = scan[PTR_W-1:0];
        req_ready[scan[PTR_W-1:0]] = 1'b1;
      end
    end
  end

  // Select the granted requester's data word.
  always_comb begin
    win_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (winner == PTR_W'(k)) begin
        win_data = req_data[k*DW +: DW];
      end
    end
  end

  // Occupancy and arbitration pointer, committed at accept time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      rr_ptr <= '0;
    end else begin
      if (wr_acc && !rd_acc) begin
        count <= count + 1'b1;
      end else if (rd_acc && !wr_acc) begin
        count <= count - 1'b1;
      end
      if (wr_acc) begin
        rr_ptr <= (winner == LAST_C) ? '0 : winner + 1'b1;
      end
    end
  end

  // Registered write strobe and data toward fifo_sync; data holds when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_en     <= 1'b0;
      fifo_data_i <= '0;
    end else begin
      fifo_en <= wr_acc;
      if (wr_acc) begin
        fifo_data_i <= win_data;
      end
    end
  end

  // Read strobe, then capture of the zero-delay FIFO output one edge later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_read <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
    end else begin
      fifo_read <= rd_acc;
      rd_valid  <= fifo_read;
      if (fifo_read) begin
        rd_data <= fifo_data_o;
      end
    end
  end

  // data_rd must mirror read exactly; any disagreement latches err.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else begin
      err <= err | (fifo_read ^ fifo_data_rd);
    end
  end

endmodule
